// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the RV32I pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        KILL = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use compare between the ID sources and EX rd.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rd,
    output logic       lu
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = id_use_rs1 & (id_rs1 == id_ex_rd);
    assign w_hit_rs2 = id_use_rs2 & (id_rs2 == id_ex_rd);

    // x0 is never really written, so a load to it cannot create a hazard
    assign lu = id_ex_mem_read & (id_ex_rd != REG_X0) & (w_hit_rs1 | w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush/redirect sequencing for the 5-stage pipeline with
//               fetch-collision redirect replay and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_ex_mem_read,
    input  logic [4:0]      id_ex_rd,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            imem_ready,
    input  logic            dmem_req,
    input  logic            dmem_ready,
    input  logic            perf_clr,
    output logic            pc_stall,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            id_ex_stall,
    output logic            id_ex_flush,
    output logic            ex_mem_stall,
    output logic            mem_wb_flush,
    output logic [XLEN-1:0] perf_stall_cycles,
    output logic [XLEN-1:0] perf_flush_count
);

    ctrl_state_e     r_state;
    logic [XLEN-1:0] r_tgt_q;
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;

    stage_ctrl_t     w_ctrl;
    logic            w_pc_stall;
    logic            w_pc_redirect;
    logic            w_capture;
    logic            w_release;
    logic            w_lu;
    logic            w_dwait;
    logic            w_iwait;

    assign w_dwait = dmem_req & ~dmem_ready;
    assign w_iwait = ~imem_ready;

    hazard_detect u_hazard_detect (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .lu             (w_lu)
    );

    always_comb begin
        w_ctrl        = '0;
        w_pc_stall    = 1'b0;
        w_pc_redirect = 1'b0;
        w_capture     = 1'b0;
        w_release     = 1'b0;
        pc_target     = (r_state == KILL) ? r_tgt_q : ex_target;
        if (rst) begin
            w_ctrl        = '0;
        end else if (w_dwait) begin
            // Freeze everything; a branch in EX simply resolves again later
            w_pc_stall          = 1'b1;
            w_ctrl.if_id_stall  = 1'b1;
            w_ctrl.id_ex_stall  = 1'b1;
            w_ctrl.ex_mem_stall = 1'b1;
            w_ctrl.mem_wb_flush = 1'b1;
        end else if (r_state == KILL) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            if (imem_ready) begin
                w_pc_redirect = 1'b1;
                w_release     = 1'b1;
            end else begin
                w_pc_stall    = 1'b1;
            end
        end else if (ex_redirect) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            if (imem_ready) begin
                w_pc_redirect = 1'b1;
            end else begin
                w_pc_stall    = 1'b1;
                w_capture     = 1'b1;
            end
        end else if (w_lu) begin
            w_pc_stall         = 1'b1;
            w_ctrl.if_id_stall = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
        end else if (w_iwait) begin
            w_pc_stall         = 1'b1;
            w_ctrl.if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_tgt_q <= '0;
        end else if (w_capture) begin
            r_state <= KILL;
            r_tgt_q <= ex_target;
        end else if (w_release) begin
            r_state <= RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + {{(XLEN-1){1'b0}}, w_pc_stall};
            r_flush_cnt <= r_flush_cnt + {{(XLEN-1){1'b0}}, w_ctrl.if_id_flush};
        end
    end

    assign pc_stall          = w_pc_stall;
    assign pc_redirect       = w_pc_redirect;
    assign if_id_stall       = w_ctrl.if_id_stall;
    assign if_id_flush       = w_ctrl.if_id_flush;
    assign id_ex_stall       = w_ctrl.id_ex_stall;
    assign id_ex_flush       = w_ctrl.id_ex_flush;
    assign ex_mem_stall      = w_ctrl.ex_mem_stall;
    assign mem_wb_flush      = w_ctrl.mem_wb_flush;
    assign perf_stall_cycles = r_stall_cnt;
    assign perf_flush_count  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl (32-bit and 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam logic [7:0] B_PCS = 8'h80, B_RED = 8'h40, B_IFS = 8'h20, B_IFF = 8'h10;
    localparam logic [7:0] B_IDS = 8'h08, B_IDF = 8'h04, B_EXS = 8'h02, B_MWB = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_use_rs1, id_use_rs2, id_ex_mem_read;
    logic        ex_redirect, imem_ready, dmem_req, dmem_ready, perf_clr;
    logic [31:0] ex_target;

    logic        pc_stall, pc_redirect, if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [31:0] pc_target, perf_stall_cycles, perf_flush_count;

    logic        s_pc_stall, s_pc_redirect, s_if_id_stall, s_if_id_flush;
    logic        s_id_ex_stall, s_id_ex_flush, s_ex_mem_stall, s_mem_wb_flush;
    logic [3:0]  s_pc_target, s_stall_cnt, s_flush_cnt;

    logic [7:0]  act, s_act;
    assign act   = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
                    id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
    assign s_act = {s_pc_stall, s_pc_redirect, s_if_id_stall, s_if_id_flush,
                    s_id_ex_stall, s_id_ex_flush, s_ex_mem_stall, s_mem_wb_flush};

    always #5 clk = ~clk;

    pipeline_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .perf_clr(perf_clr), .pc_stall(pc_stall), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
    );

    // Narrow-counter copy so the modulo wrap is reachable in a few cycles
    pipeline_ctrl #(.XLEN(4)) dut_w (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .ex_redirect(ex_redirect), .ex_target(ex_target[3:0]),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .perf_clr(perf_clr), .pc_stall(s_pc_stall), .pc_redirect(s_pc_redirect),
        .pc_target(s_pc_target), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
        .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
        .ex_mem_stall(s_ex_mem_stall), .mem_wb_flush(s_mem_wb_flush),
        .perf_stall_cycles(s_stall_cnt), .perf_flush_count(s_flush_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_kill;
    logic [31:0] m_tgt, m_sc, m_fc;
    logic [3:0]  m_ws, m_wf;
    logic [7:0]  e_strb;
    logic [31:0] e_tgt;
    bit          n_kill;
    logic [31:0] n_tgt;

    task automatic model_eval();
        bit frozen, hazard;
        if (rst) begin
            m_kill = 0; m_tgt = '0; m_sc = '0; m_fc = '0; m_ws = '0; m_wf = '0;
        end
        frozen = dmem_req && !dmem_ready;
        hazard = id_ex_mem_read && (id_ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
        n_kill = m_kill;
        n_tgt  = m_tgt;
        e_tgt  = m_kill ? m_tgt : ex_target;
        if (rst)                         e_strb = 8'h00;
        else if (frozen)                 e_strb = B_PCS | B_IFS | B_IDS | B_EXS | B_MWB;
        else if (m_kill && imem_ready) begin
            e_strb = B_RED | B_IFF | B_IDF; n_kill = 0;
        end
        else if (m_kill)                 e_strb = B_PCS | B_IFF | B_IDF;
        else if (ex_redirect && imem_ready) e_strb = B_RED | B_IFF | B_IDF;
        else if (ex_redirect) begin
            e_strb = B_PCS | B_IFF | B_IDF; n_kill = 1; n_tgt = ex_target;
        end
        else if (hazard)                 e_strb = B_PCS | B_IFS | B_IDF;
        else if (!imem_ready)            e_strb = B_PCS | B_IFF;
        else                             e_strb = 8'h00;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_sc = perf_clr ? 32'd0 : m_sc + (e_strb[7] ? 32'd1 : 32'd0);
            m_fc = perf_clr ? 32'd0 : m_fc + (e_strb[4] ? 32'd1 : 32'd0);
            m_ws = perf_clr ? 4'd0  : m_ws + (e_strb[7] ? 4'd1 : 4'd0);
            m_wf = perf_clr ? 4'd0  : m_wf + (e_strb[4] ? 4'd1 : 4'd0);
            m_kill = n_kill;
            m_tgt  = n_tgt;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_ex_mem_read = 0; id_ex_rd = 0; ex_redirect = 0; ex_target = 32'h0;
        imem_ready = 1; dmem_req = 0; dmem_ready = 0; perf_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); imem_ready = 0; ex_redirect = 1; dmem_req = 1;
        settle();
        n_cmp++; if (act !== 8'h00) begin n_err++; $display("FAIL reset_strobes: got %h want 00", act); end
        n_cmp++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
            n_err++; $display("FAIL reset_counters: got %h/%h want 0/0", perf_stall_cycles, perf_flush_count); end
        tick();
        rst = 0; idle_inputs();
        settle();
        n_cmp++; if (act !== 8'h00) begin n_err++; $display("FAIL idle_strobes: got %h want 00", act); end
        tick();
    endtask

    task automatic test_load_use();
        id_ex_mem_read = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        settle();
        n_cmp++; if (act !== (B_PCS | B_IFS | B_IDF)) begin
            n_err++; $display("FAIL load_use: got %h want %h", act, B_PCS | B_IFS | B_IDF); end
        tick();
        id_ex_mem_read = 0; id_ex_rd = 7;
        settle();
        n_cmp++; if (act !== 8'h00) begin n_err++; $display("FAIL load_use_after: got %h want 00", act); end
        tick();
        id_ex_mem_read = 1; id_ex_rd = 0; id_rs1 = 0;
        settle();
        n_cmp++; if (act !== 8'h00) begin n_err++; $display("FAIL load_use_x0: got %h want 00", act); end
        tick();
        idle_inputs();
    endtask

    task automatic test_redirect();
        logic [31:0] prev;
        prev = m_fc;
        ex_redirect = 1; ex_target = 32'h0000_0100;
        settle();
        n_cmp++; if (act !== (B_RED | B_IFF | B_IDF) || pc_target !== 32'h100) begin
            n_err++; $display("FAIL redirect: got %h/%h want %h/00000100", act, pc_target, B_RED | B_IFF | B_IDF); end
        tick();
        idle_inputs();
        settle();
        n_cmp++; if (perf_flush_count !== prev + 32'd1) begin
            n_err++; $display("FAIL redirect_flushcnt: got %0d want %0d", perf_flush_count, prev + 32'd1); end
        tick();
    endtask

    task automatic test_kill();
        ex_redirect = 1; ex_target = 32'h200; imem_ready = 0;
        settle();
        n_cmp++; if (act !== (B_PCS | B_IFF | B_IDF)) begin
            n_err++; $display("FAIL kill_enter: got %h want %h", act, B_PCS | B_IFF | B_IDF); end
        tick();
        ex_redirect = 0; ex_target = 32'h3C;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if (act !== (B_PCS | B_IFF | B_IDF) || pc_target !== 32'h200) begin
                n_err++; $display("FAIL kill_wait: got %h/%h want %h/00000200", act, pc_target, B_PCS | B_IFF | B_IDF); end
            tick();
        end
        imem_ready = 1;
        settle();
        n_cmp++; if (act !== (B_RED | B_IFF | B_IDF) || pc_target !== 32'h200) begin
            n_err++; $display("FAIL kill_replay: got %h/%h want %h/00000200", act, pc_target, B_RED | B_IFF | B_IDF); end
        tick();
        settle();
        n_cmp++; if (act !== 8'h00 || pc_target !== 32'h3C) begin
            n_err++; $display("FAIL kill_exit: got %h/%h want 00/0000003c", act, pc_target); end
        tick();
        idle_inputs();
    endtask

    task automatic test_dwait_redirect();
        logic [31:0] prev;
        prev = m_sc;
        dmem_req = 1; dmem_ready = 0; ex_redirect = 1; ex_target = 32'h300;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_cmp++; if (act !== (B_PCS | B_IFS | B_IDS | B_EXS | B_MWB)) begin
                n_err++; $display("FAIL dwait_freeze: got %h want %h", act, B_PCS | B_IFS | B_IDS | B_EXS | B_MWB); end
            tick();
        end
        dmem_ready = 1;
        settle();
        n_cmp++; if (act !== (B_RED | B_IFF | B_IDF) || pc_target !== 32'h300) begin
            n_err++; $display("FAIL dwait_release: got %h/%h want %h/00000300", act, pc_target, B_RED | B_IFF | B_IDF); end
        n_cmp++; if (perf_stall_cycles !== prev + 32'd4) begin
            n_err++; $display("FAIL dwait_stallcnt: got %0d want %0d", perf_stall_cycles, prev + 32'd4); end
        tick();
        idle_inputs();
        settle();
        n_cmp++; if (perf_stall_cycles !== prev + 32'd4) begin
            n_err++; $display("FAIL dwait_stallhold: got %0d want %0d", perf_stall_cycles, prev + 32'd4); end
        tick();
    endtask

    task automatic test_reset_in_kill();
        ex_redirect = 1; ex_target = 32'h480; imem_ready = 0;
        settle();
        tick();
        ex_redirect = 0; ex_target = 32'h55;
        rst = 1;
        settle();
        n_cmp++; if (act !== 8'h00 || perf_stall_cycles !== 0 || perf_flush_count !== 0) begin
            n_err++; $display("FAIL rst_in_kill: got %h/%0d/%0d want 00/0/0", act, perf_stall_cycles, perf_flush_count); end
        tick();
        rst = 0; imem_ready = 1;
        settle();
        n_cmp++; if (act !== 8'h00 || pc_target !== 32'h55) begin
            n_err++; $display("FAIL rst_release: got %h/%h want 00/00000055", act, pc_target); end
        tick();
        idle_inputs();
    endtask

    task automatic test_wrap();
        perf_clr = 1;
        settle(); tick();
        perf_clr = 0; imem_ready = 0;
        for (int i = 0; i < 16; i++) begin
            settle();
            if (i == 15) begin
                n_cmp++; if (s_stall_cnt !== 4'd15) begin
                    n_err++; $display("FAIL wrap_top: got %0d want 15", s_stall_cnt); end
            end
            tick();
        end
        settle();
        n_cmp++; if (s_stall_cnt !== 4'd0 || perf_stall_cycles !== 32'd16) begin
            n_err++; $display("FAIL wrap_zero: got %0d/%0d want 0/16", s_stall_cnt, perf_stall_cycles); end
        perf_clr = 1;
        tick();
        perf_clr = 0;
        settle();
        n_cmp++; if (s_stall_cnt !== 4'd0 || perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
            n_err++; $display("FAIL clr_wins: got %0d/%0d/%0d want 0/0/0", s_stall_cnt, perf_stall_cycles, perf_flush_count); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1     = $urandom_range(0, 1) == 1;
            id_use_rs2     = $urandom_range(0, 1) == 1;
            id_ex_mem_read = $urandom_range(0, 2) == 0;
            ex_redirect    = $urandom_range(0, 4) == 0;
            ex_target      = $urandom;
            imem_ready     = $urandom_range(0, 3) != 0;
            dmem_req       = $urandom_range(0, 2) == 0;
            dmem_ready     = $urandom_range(0, 1) == 1;
            perf_clr       = $urandom_range(0, 39) == 0;
            settle();
            n_cmp++; if (act !== e_strb || pc_target !== e_tgt) begin
                n_err++; $display("FAIL rand_strobes[%0d]: got %h/%h want %h/%h", i, act, pc_target, e_strb, e_tgt); end
            n_cmp++; if (perf_stall_cycles !== m_sc || perf_flush_count !== m_fc) begin
                n_err++; $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", i, perf_stall_cycles, perf_flush_count, m_sc, m_fc); end
            n_cmp++; if (s_act !== e_strb || s_pc_target !== e_tgt[3:0] || s_stall_cnt !== m_ws || s_flush_cnt !== m_wf) begin
                n_err++; $display("FAIL rand_narrow[%0d]: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", i,
                    s_act, s_pc_target, s_stall_cnt, s_flush_cnt, e_strb, e_tgt[3:0], m_ws, m_wf); end
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        m_kill = 0; m_tgt = '0; m_sc = '0; m_fc = '0; m_ws = '0; m_wf = '0;
        rst = 1; idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_kill();
        test_dwait_redirect();
        test_reset_in_kill();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
